// File: rtl/fp_tb_pkg.sv
// Shared definitions for the FP multiplier stimulus and capture blocks:
// default word width, per-variant multiplier latency and the sink FSM encoding.
package fp_tb_pkg;

   localparam int FP_DATA_W = 32;

   // Input-to-output latency of each multiplier variant
   localparam int FPMUL_LATENCY_COMB = 1;
   localparam int FPMUL_LATENCY_FAST = 3;
   localparam int FPMUL_LATENCY_STD  = 5;
   localparam int FPMUL_LATENCY_DSP  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sink_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port. Pointers carry one extra
// wrap bit so that full and empty can be told apart when the indices match.
module sync_fifo
   import fp_tb_pkg::*;
#(
   parameter int DATA_W = FP_DATA_W,
   parameter int DEPTH  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_req,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_req,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_vld,
   output logic              o_wr_fire,
   output logic              o_drop,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_rd_fire;
   logic              w_wr_fire;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_rd_fire = i_rd_req && !o_empty;
   // A full FIFO still accepts a write when a read frees the head slot
   assign w_wr_fire = i_wr_req && (!o_full || w_rd_fire);
   assign o_wr_fire = w_wr_fire;
   assign o_drop    = i_wr_req && !w_wr_fire;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         o_rd_data <= '0;
         o_rd_vld  <= 1'b0;
      end else begin
         o_rd_vld <= w_rd_fire;
         if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd_fire) begin
            r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            o_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
         end
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (w_wr_fire) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/fp_stream_sink.sv
// Capture end of the FP multiplier sample stream: realigns the sample strobe
// to the product, buffers results, counts them and reports run/drain/done.
module fp_stream_sink
   import fp_tb_pkg::*;
#(
   parameter int DATA_W  = FP_DATA_W,
   parameter int LATENCY = FPMUL_LATENCY_STD,
   parameter int DEPTH   = 16,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SMPL_STAT,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              RD_EN,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VLD,
   output logic              EMPTY,
   output logic              FULL,
   output logic              OVF,
   output logic [CNT_W-1:0]  SMPL_CNT,
   output logic              DONE
);

   localparam int DRAIN_W = $clog2(LATENCY + 1);

   logic [LATENCY-1:0] r_vld_pipe;
   logic               w_res_vld;
   logic               w_wr_fire;
   logic               w_drop;
   logic [CNT_W-1:0]   r_smpl_cnt;
   logic               r_ovf;
   sink_state_e        r_state;
   sink_state_e        w_state_nxt;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [DRAIN_W-1:0] w_drain_cnt_nxt;

   assign w_res_vld = r_vld_pipe[LATENCY-1];

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_wr_req  (w_res_vld),
      .i_wr_data (DATA_IN),
      .i_rd_req  (RD_EN),
      .o_rd_data (RD_DATA),
      .o_rd_vld  (RD_VLD),
      .o_wr_fire (w_wr_fire),
      .o_drop    (w_drop),
      .o_full    (FULL),
      .o_empty   (EMPTY)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vld_pipe  <= '0;
         r_smpl_cnt  <= '0;
         r_ovf       <= 1'b0;
         r_state     <= ST_IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_vld_pipe[0] <= SMPL_STAT;
         for (int i = 1; i < LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
         if (w_wr_fire && (r_smpl_cnt != '1)) r_smpl_cnt <= r_smpl_cnt + CNT_W'(1);
         if (w_drop) r_ovf <= 1'b1;
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
      end
   end

   // drain_cnt covers the products still inside the multiplier after the stream stops
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_state_nxt     = r_state;
      w_drain_cnt_nxt = r_drain_cnt;
      case (r_state)
         ST_IDLE: begin
            if (SMPL_STAT) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!SMPL_STAT) begin
               w_state_nxt     = ST_DRAIN;
               w_drain_cnt_nxt = DRAIN_W'(LATENCY);
            end
         end
         ST_DRAIN: begin
            w_drain_cnt_nxt = r_drain_cnt - DRAIN_W'(1);
            if (SMPL_STAT)                          w_state_nxt = ST_RUN;
            else if (r_drain_cnt == DRAIN_W'(1))    w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign SMPL_CNT = r_smpl_cnt;
   assign OVF      = r_ovf;
   assign DONE     = (r_state == ST_DONE);

endmodule

// File: tb/tb_fp_stream_sink.sv
// Randomized bench for fp_stream_sink against a queue-based reference model
// that tracks due times of samples, FIFO contents and the time of the last sample.
module tb_fp_stream_sink;

   localparam int DATA_W  = 32;
   localparam int LATENCY = 5;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              smpl_stat;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_vld;
   logic              empty;
   logic              full;
   logic              ovf;
   logic [CNT_W-1:0]  smpl_cnt;
   logic              done;

   always #5 clk = ~clk;

   fp_stream_sink #(
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .SMPL_STAT (smpl_stat),
      .DATA_IN   (data_in),
      .RD_EN     (rd_en),
      .RD_DATA   (rd_data),
      .RD_VLD    (rd_vld),
      .EMPTY     (empty),
      .FULL      (full),
      .OVF       (ovf),
      .SMPL_CNT  (smpl_cnt),
      .DONE      (done)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   // Reference model state
   int                m_due[$];
   logic [DATA_W-1:0] m_fifo[$];
   logic [DATA_W-1:0] m_rd_data;
   logic              m_rd_vld;
   logic              m_ovf;
   logic [CNT_W-1:0]  m_cnt;
   logic              m_done;
   logic              m_started;
   int                m_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Advances the model by one clock using the inputs presented this cycle.
   task automatic model_cycle();
      logic res_vld;
      logic rd_fire;
      logic wr_fire;
      int   tmp;
      if (rst) begin
         m_due.delete();
         m_fifo.delete();
         m_rd_data = '0;
         m_rd_vld  = 1'b0;
         m_ovf     = 1'b0;
         m_cnt     = '0;
         m_done    = 1'b0;
         m_started = 1'b0;
         m_last    = 0;
      end else begin
         res_vld = (m_due.size() > 0) && (m_due[0] == cyc);
         if (res_vld) tmp = m_due.pop_front();
         rd_fire  = rd_en && (m_fifo.size() > 0);
         wr_fire  = res_vld && ((m_fifo.size() < DEPTH) || rd_fire);
         m_rd_vld = rd_fire;
         if (rd_fire) m_rd_data = m_fifo.pop_front();
         if (wr_fire) begin
            m_fifo.push_back(data_in);
            if (m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
         end else if (res_vld) begin
            m_ovf = 1'b1;
         end
         if (smpl_stat) begin
            m_due.push_back(cyc + LATENCY);
            if (!m_done) begin
               m_started = 1'b1;
               m_last    = cyc;
            end
         end
         // Done once LATENCY+2 cycles have passed since the last sample of the stream
         if (m_started && ((cyc + 1 - m_last) >= LATENCY + 2)) m_done = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic s, input logic [DATA_W-1:0] d, input logic re);
      rst       = r;
      smpl_stat = s;
      data_in   = d;
      rd_en     = re;
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      check("rd_vld",   32'(rd_vld),   32'(m_rd_vld));
      check("rd_data",  rd_data,       m_rd_data);
      check("empty",    32'(empty),    32'(m_fifo.size() == 0));
      check("full",     32'(full),     32'(m_fifo.size() == DEPTH));
      check("ovf",      32'(ovf),      32'(m_ovf));
      check("smpl_cnt", 32'(smpl_cnt), 32'(m_cnt));
      check("done",     32'(done),     32'(m_done));
   endtask

   initial begin
      rst = 1'b1; smpl_stat = 1'b0; data_in = '0; rd_en = 1'b0;

      // Reset state
      step(1, 0, 32'h0, 0);
      step(1, 1, $urandom, 1);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_cnt",   32'(smpl_cnt), 32'd0);

      // Single sample with product 0x40800000 LATENCY cycles later
      step(0, 1, $urandom, 0);
      for (int i = 1; i <= 8; i++) step(0, 0, (i == LATENCY) ? 32'h4080_0000 : $urandom, 0);
      check("single_done", 32'(done), 32'd1);
      step(0, 0, $urandom, 1);
      check("single_data", rd_data, 32'h4080_0000);
      for (int i = 0; i < 3; i++) step(0, 0, $urandom, 1);

      // Burst of 20 without reads: 16 kept, 4 dropped, then drain in order
      step(1, 0, $urandom, 0);
      for (int i = 0; i < 20; i++) step(0, 1, $urandom, 0);
      for (int i = 0; i < 10; i++) step(0, 0, $urandom, 0);
      check("burst_full", 32'(full), 32'd1);
      check("burst_ovf",  32'(ovf),  32'd1);
      check("burst_cnt",  32'(smpl_cnt), 32'd16);
      for (int i = 0; i < 18; i++) step(0, 0, $urandom, 1);
      check("burst_empty", 32'(empty), 32'd1);

      // Full FIFO with RD_EN held through a continuous stream, across pointer wrap
      step(1, 0, $urandom, 0);
      for (int i = 0; i < 80; i++) step(0, 1, $urandom, (i >= LATENCY + 16));
      check("stream_full", 32'(full), 32'd1);
      for (int i = 0; i < 30; i++) step(0, 0, $urandom, 1);
      check("stream_ovf", 32'(ovf), 32'd0);
      check("stream_cnt", 32'(smpl_cnt), 32'd80);

      // Gap of 3 cycles inside a stream
      step(1, 0, $urandom, 0);
      for (int i = 0; i < 6; i++) step(0, 1, $urandom, 0);
      for (int i = 0; i < 3; i++) step(0, 0, $urandom, 0);
      for (int i = 0; i < 6; i++) step(0, 1, $urandom, 0);
      check("gap_done", 32'(done), 32'd0);
      for (int i = 0; i < 12; i++) step(0, 0, $urandom, $urandom_range(0, 1));

      // Reset mid-burst with 8 words buffered and 3 in flight
      step(1, 0, $urandom, 0);
      for (int i = 0; i < 11; i++) step(0, 1, $urandom, 0);
      for (int i = 0; i < 2; i++) step(0, 0, $urandom, 0);
      check("pre_rst_cnt", 32'(smpl_cnt), 32'd8);
      step(1, 0, $urandom, 0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_cnt",   32'(smpl_cnt), 32'd0);
      check("mid_rst_done",  32'(done), 32'd0);
      for (int i = 0; i < 12; i++) step(0, 0, $urandom, 0);
      check("post_rst_empty", 32'(empty), 32'd1);

      // Random traffic with occasional reset
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), $urandom,
              ($urandom_range(0, 9) < 4));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fp_stream_sink.md
Name: fp_stream_sink

Overview:
- Synthesizable capture end of the sample stream that drives the FP multiplier benches and FPGA bring-up.
- The stimulus side presents DATA plus SMPL_STAT. This block realigns SMPL_STAT to the multiplier output through a LATENCY-deep valid pipe.
- Valid results are buffered in a FIFO for later read-out.
- Also provides a sample count and a run/drain/done status, so a bench or host knows when the last product has arrived.

Parameters:
- DATA_W, 32, width of the FP word captured from the multiplier output.
- LATENCY, 5, cycles from a sample on the multiplier input to its product on the output; legal range 1 to 16.
- DEPTH, 16, number of FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- CLK, in, 1, single clock; all logic updates on the rising edge.
- RST, in, 1, synchronous, active-high reset.
- SMPL_STAT, in, 1, high when the stimulus presents a valid sample to the multiplier this cycle.
- DATA_IN, in, DATA_W, multiplier output FP_Z.
- RD_EN, in, 1, read request from the consumer.
- RD_DATA, out, DATA_W, registered FIFO head.
- RD_VLD, out, 1, RD_DATA holds a new word this cycle.
- EMPTY, out, 1, FIFO holds zero entries.
- FULL, out, 1, FIFO holds DEPTH entries.
- OVF, out, 1, sticky flag: at least one result was dropped.
- SMPL_CNT, out, CNT_W, number of results written to the FIFO.
- DONE, out, 1, stream ended and the pipeline is drained.

Behaviour:
- Reset values, all taking effect on the first CLK edge with RST=1: RD_DATA=0, RD_VLD=0, EMPTY=1, FULL=0, OVF=0, SMPL_CNT=0, DONE=0. The valid pipe and both FIFO pointers clear; the FSM goes to IDLE.
- Valid pipe: a LATENCY-bit shift register. Bit 0 loads SMPL_STAT each cycle. res_vld is the top bit, so DATA_IN is sampled exactly LATENCY cycles after the matching SMPL_STAT=1.
- FIFO pointers have log2(DEPTH)+1 bits, with the extra bit used for wrap detection.
  - EMPTY when the pointers are equal.
  - FULL when the index bits are equal and the MSBs differ.
- Read: rd_fire = RD_EN and not EMPTY.
  - On rd_fire, RD_DATA takes the head entry at the next edge and RD_VLD=1 for that one cycle.
  - RD_EN while EMPTY is ignored; RD_VLD=0 and RD_DATA holds its value.
- Write: wr_fire = res_vld and (not FULL or rd_fire).
  - A simultaneous read and write while FULL succeeds for both; occupancy is unchanged.
  - A simultaneous read and write while EMPTY: the write is taken and the read is ignored.
  - res_vld while FULL with no rd_fire: the word is dropped and OVF is set, staying set until reset.
- SMPL_CNT increments on each wr_fire and saturates at all-ones.
- FSM, with DONE=1 only in state DONE:
  - IDLE: moves to RUN on SMPL_STAT=1.
  - RUN: moves to DRAIN on SMPL_STAT=0, loading drain_cnt=LATENCY.
  - DRAIN: decrements drain_cnt each cycle. Returns to RUN if SMPL_STAT=1 (stream resumed). Moves to DONE when drain_cnt reaches 1 and SMPL_STAT=0.
  - DONE: terminal until RST. SMPL_STAT is ignored for the FSM, but the valid pipe and FIFO keep working.
- Reset in any state or mid-burst discards all in-flight valid bits and FIFO contents. No result straddles a reset.
- Pointer wrap-around at DEPTH is seamless; there is no bubble.

Decomposition:
- Shared package fp_tb_pkg holds:
  - DATA_W default;
  - the FSM state encoding, 2 bits: IDLE=0, RUN=1, DRAIN=2, DONE=3;
  - the FPMUL_LATENCY constant for each multiplier variant.
- One sub-module, sync_fifo: single-clock FIFO taking DATA_W and DEPTH, with FULL/EMPTY and registered read.
- The valid pipe, counter and FSM stay in the top level.

Test Plan:
- Single sample, LATENCY=5: SMPL_STAT=1 at cycle 0 with FP_Z=0x40800000 at cycle 5.
  - Expect EMPTY to fall at cycle 6 and SMPL_CNT=1.
  - RD_EN then gives RD_DATA=0x40800000 with RD_VLD one cycle later.
  - DONE=1 at cycle 7.
- Burst of 20 samples, no reads, DEPTH=16: first 16 words stored, FULL=1, OVF=1, SMPL_CNT=16, last 4 dropped.
  - Reading out 16 words returns them in order, then EMPTY=1.
- FULL with RD_EN=1 held through a continuous stream: every result accepted, OVF stays 0, occupancy constant at 16, words returned in order across pointer wrap.
- Gap of 3 cycles inside a stream (fewer than LATENCY): FSM goes RUN→DRAIN→RUN, DONE stays 0.
  - DONE rises LATENCY+1 cycles after the final SMPL_STAT fall.
- RST pulsed for 1 cycle mid-burst with 8 words buffered and 3 in flight: EMPTY=1, SMPL_CNT=0, OVF=0, DONE=0.
  - The 3 in-flight products are never written.
- RD_EN=1 while EMPTY: RD_VLD stays 0, RD_DATA unchanged, pointers unchanged.
